// File: rtl/mpsoc_wb_pkg.sv
// mpsoc_wb_pkg: Wishbone cycle/burst type codes, bridge FSM states and a CTI classifier.
package mpsoc_wb_pkg;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;
    typedef enum logic [1:0] {ST_IDLE, ST_CLASSIC, ST_BURST} state_t;
    function automatic logic is_classic(input logic [2:0] cti);
        return cti == CTI_CLASSIC || cti == CTI_CONST || cti == CTI_END;
    endfunction
endpackage

// File: rtl/mpsoc_wb_burst_addr.sv
// mpsoc_wb_burst_addr: next burst word address; adr/bte in, nxt out (linear mod DEPTH or wrap4/8/16).
module mpsoc_wb_burst_addr
    import mpsoc_wb_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0] adr,
    input  logic [1:0]    bte,
    output logic [AW-1:0] nxt
);
    logic [AW-1:0] inc, lin, mask;
    assign inc  = adr + AW'(1);
    assign lin  = adr == AW'(DEPTH - 1) ? '0 : inc;
    // only the masked low bits advance in a wrapping burst; the rest stay fixed
    assign mask = bte == BTE_WRAP4 ? AW'(4'h3) : bte == BTE_WRAP8 ? AW'(4'h7) : AW'(4'hf);
    assign nxt  = bte == BTE_LINEAR ? lin : (adr & ~mask) | (inc & mask);
endmodule

// File: rtl/mpsoc_wb_ram_bridge.sv
// mpsoc_wb_ram_bridge: Wishbone slave to 1-cycle-latency RAM; wb_* bus in/out, ram_* write port, read address and read data.
// Burst (cti=010) support is compiled in with MPSOC_WB_RAM_BRIDGE_BURST_EN; otherwise every access is classic.
module mpsoc_wb_ram_bridge
    import mpsoc_wb_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [AW+1:0] wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [3:0]    ram_we,
    output logic [DW-1:0] ram_din,
    output logic [AW-1:0] ram_waddr,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_dout
);
    state_t        state;
    logic [AW-1:0] adr_r, wadr;
    logic          ack_r, err_r, valid, beat, burst, err_req, unused;
    assign valid     = wb_cyc_i & wb_stb_i;
    assign wadr      = wb_adr_i[AW+1:2];
    // reset must silence the bus in the very cycle it is asserted
    assign wb_ack_o  = ack_r & ~wb_rst_i;
    assign wb_err_o  = err_r & ~wb_rst_i;
    assign beat      = wb_ack_o & valid;
    assign wb_dat_o  = ram_dout;
    assign ram_we    = wb_sel_i & {4{wb_we_i & beat}};
    assign ram_waddr = adr_r;
    assign ram_din   = wb_dat_i;
    assign err_req   = !(is_classic(wb_cti_i) || wb_cti_i == CTI_INCR);
`ifdef MPSOC_WB_RAM_BRIDGE_BURST_EN
    logic [AW-1:0] adr_nxt;
    mpsoc_wb_burst_addr #(.DEPTH(DEPTH), .AW(AW)) u_burst_addr (
        .adr(adr_r),
        .bte(wb_bte_i),
        .nxt(adr_nxt)
    );
    assign burst  = wb_cti_i == CTI_INCR;
    // prefetch the following beat so read data is ready in every ack cycle
    assign ram_raddr = state == ST_IDLE ? wadr : (state == ST_BURST && beat) ? adr_nxt : adr_r;
    assign unused = ^wb_adr_i[1:0];
`else
    assign burst  = 1'b0;
    assign ram_raddr = wadr;
    assign unused = ^{wb_adr_i[1:0], wb_bte_i};
`endif
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
            ack_r <= 1'b0;
            err_r <= 1'b0;
            adr_r <= '0;
        end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            case (state)
                ST_IDLE: if (valid) begin
                    adr_r <= wadr;
                    state <= burst ? ST_BURST : ST_CLASSIC;
                    ack_r <= !err_req;
                    err_r <= err_req;
                end
`ifdef MPSOC_WB_RAM_BRIDGE_BURST_EN
                ST_BURST: begin
                    if (beat) adr_r <= adr_nxt;
                    // a stalled strobe re-arms ack one cycle after it returns
                    if (!wb_cyc_i || (beat && wb_cti_i == CTI_END)) state <= ST_IDLE;
                    else ack_r <= wb_stb_i;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mpsoc_wb_ram_bridge.sv
// tb_mpsoc_wb_ram_bridge: directed checks of classic, error, burst and reset behaviour against a byte-lane RAM model.
module tb_mpsoc_wb_ram_bridge;
    logic        clk = 1'b0, rst = 1'b1, init = 1'b1;
    logic [9:0]  adr;
    logic [31:0] dat_i, dat_o, ram_din, ram_dout;
    logic [3:0]  sel, ram_we;
    logic        we, cyc, stb, ack, err;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [7:0]  ram_waddr, ram_raddr;
    logic [31:0] mem [256];
    int total = 0, bad = 0;

    mpsoc_wb_ram_bridge dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_ack_o(ack), .wb_err_o(err), .wb_dat_o(dat_o), .ram_we(ram_we), .ram_din(ram_din),
        .ram_waddr(ram_waddr), .ram_raddr(ram_raddr), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + i;
        end else begin
            for (int b = 0; b < 4; b++) if (ram_we[b]) mem[ram_waddr][8*b+:8] <= ram_din[8*b+:8];
        end
        ram_dout <= mem[ram_raddr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic w, input logic [9:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic [2:0] c, input logic [1:0] e);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d; cti = c; bte = e;
    endtask

    task automatic idle_bus();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        req(1'b1, 10'h010, 4'hf, 32'h0, 3'b000, 2'b00);
        step(); step();
        @(negedge clk);
        chk("rst_ack", ack, 0); chk("rst_err", err, 0); chk("rst_we", ram_we, 0);
        step(); rst = 1'b0; init = 1'b0; idle_bus();
        step();
        // classic partial write
        step(); req(1'b1, 10'h010, 4'b0101, 32'hAABBCCDD, 3'b000, 2'b00);
        @(negedge clk); chk("cw_wait", ack, 0);
        step(); @(negedge clk);
        chk("cw_ack", ack, 1); chk("cw_we", ram_we, 4'b0101); chk("cw_waddr", ram_waddr, 4); chk("cw_err", err, 0);
        step(); idle_bus(); @(negedge clk); chk("cw_ack_end", ack, 0); chk("cw_we_end", ram_we, 0);
        step(); req(1'b0, 10'h010, 4'hf, 32'h0, 3'b000, 2'b00);
        step(); @(negedge clk); chk("rb_ack", ack, 1); chk("rb_dat", dat_o, 32'h10BB00DD);
        step(); idle_bus();
        // classic full write then read
        step(); req(1'b1, 10'h020, 4'hf, 32'h12345678, 3'b000, 2'b00);
        step(); step(); idle_bus();
        step(); req(1'b0, 10'h020, 4'hf, 32'h0, 3'b001, 2'b00);
        @(negedge clk); chk("cr_wait", ack, 0);
        step(); @(negedge clk); chk("cr_ack", ack, 1); chk("cr_dat", dat_o, 32'h12345678);
        step(); idle_bus(); @(negedge clk); chk("cr_ack_end", ack, 0);
        // reserved cycle type
        step(); req(1'b1, 10'h030, 4'hf, 32'hFFFFFFFF, 3'b100, 2'b00);
        @(negedge clk); chk("er_wait", err, 0);
        step(); @(negedge clk); chk("er_err", err, 1); chk("er_ack", ack, 0); chk("er_we", ram_we, 0);
        step(); idle_bus(); @(negedge clk); chk("er_end", err, 0);
        step(); req(1'b0, 10'h030, 4'hf, 32'h0, 3'b000, 2'b00);
        step(); @(negedge clk); chk("er_mem", dat_o, 32'h1000000C);
        step(); idle_bus();
`ifdef MPSOC_WB_RAM_BRIDGE_BURST_EN
        // wrap4 read burst from word 6
        step(); req(1'b0, 10'h018, 4'hf, 32'h0, 3'b010, 2'b01);
        @(negedge clk); chk("w4_wait", ack, 0);
        step(); @(negedge clk); chk("w4_ack0", ack, 1); chk("w4_d0", dat_o, 32'h10000006);
        step(); @(negedge clk); chk("w4_ack1", ack, 1); chk("w4_d1", dat_o, 32'h10000007);
        step(); @(negedge clk); chk("w4_ack2", ack, 1); chk("w4_d2", dat_o, 32'h10BB00DD);
        step(); cti = 3'b111; @(negedge clk); chk("w4_ack3", ack, 1); chk("w4_d3", dat_o, 32'h10000005);
        step(); idle_bus(); adr = 10'h03C; @(negedge clk); chk("w4_end", ack, 0); chk("w4_idle", ram_raddr, 15);
        // linear burst with a two-cycle strobe stall after beat 2
        step(); req(1'b0, 10'h100, 4'hf, 32'h0, 3'b010, 2'b00);
        step(); @(negedge clk); chk("lb_ack0", ack, 1); chk("lb_d0", dat_o, 32'h10000040);
        step(); @(negedge clk); chk("lb_ack1", ack, 1); chk("lb_d1", dat_o, 32'h10000041);
        step(); stb = 1'b0;
        step(); @(negedge clk); chk("lb_stall", ack, 0); chk("lb_hold", ram_raddr, 66);
        step(); stb = 1'b1; @(negedge clk); chk("lb_resume", ack, 0);
        step(); cti = 3'b111; @(negedge clk); chk("lb_ack2", ack, 1); chk("lb_d2", dat_o, 32'h10000042);
        step(); idle_bus(); @(negedge clk); chk("lb_end", ack, 0);
`else
        // incrementing cycle type behaves as a single classic access
        step(); req(1'b0, 10'h018, 4'hf, 32'h0, 3'b010, 2'b01);
        step(); @(negedge clk); chk("nb_ack", ack, 1); chk("nb_dat", dat_o, 32'h10000006);
        step(); @(negedge clk); chk("nb_ack_end", ack, 0);
        step(); idle_bus();
`endif
        // reset in the middle of a write burst
        step(); req(1'b1, 10'h200, 4'hf, 32'hDEADBEEF, 3'b010, 2'b00);
        step(); @(negedge clk); chk("rb0_ack", ack, 1); chk("rb0_we", ram_we, 4'hf);
        step(); rst = 1'b1; @(negedge clk); chk("rr_ack", ack, 0); chk("rr_we", ram_we, 0);
        step(); rst = 1'b0; @(negedge clk); chk("rr_post", ack, 0); chk("rr_idle", ram_raddr, 128);
        step(); cti = 3'b111; @(negedge clk); chk("rr_ack", ack, 1);
        step(); idle_bus(); @(negedge clk); chk("rr_end", ack, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
